// File: rtl/m6809_bus_pkg.sv
// Shared types and helpers for the 6809 memory-map decoder.
package m6809_bus_pkg;

  localparam int unsigned MAX_REGIONS = 8;
  localparam int unsigned MAX_ADDR_W  = 32;

  typedef logic [MAX_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

  // Callers zero-extend narrower addresses into addr_t.
  function automatic logic region_match(input addr_t addr, input addr_t base, input addr_t mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/m6809_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so the max load never wraps.
module m6809_wait_counter #(
  parameter int unsigned WS_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [WS_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/m6809_bus_decoder.sv
// N-region memory-map decoder with per-region wait states and registered read return.
// Optional bus-error unit for unmapped accesses: define M6809_BUSERR_EN.
module m6809_bus_decoder
  import m6809_bus_pkg::*;
#(
  parameter int unsigned                     NUM_REGIONS   = 4,
  parameter int unsigned                     ADDR_W        = 16,
  parameter int unsigned                     DATA_W        = 8,
  parameter int unsigned                     WS_W          = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE   = {16'h8000, 16'h0000, 16'h0000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK   = {16'h8000, 16'h8000, 16'h0000, 16'h0000},
  parameter logic [NUM_REGIONS*WS_W-1:0]     REGION_WAIT   = '0,
  parameter logic [DATA_W-1:0]               UNMAPPED_DATA = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic                          cpu_rw_n,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_ready,
  output logic [NUM_REGIONS-1:0]        dev_sel,
  output logic                          dev_we,
  output logic [ADDR_W-1:0]             dev_addr,
  output logic [DATA_W-1:0]             dev_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
  input  logic                          fault_clr,
  output logic                          fault,
  output logic [ADDR_W-1:0]             fault_addr
);

  bus_state_t             state, state_nxt;
  logic [NUM_REGIONS-1:0] hit_oh, sel_q;
  logic [ADDR_W-1:0]      off_addr;
  logic [WS_W-1:0]        hit_wait;
  logic [DATA_W-1:0]      rd_mux;
  logic                   found, rw_n_q, accept, last, cnt_zero;

  // Priority decode: the first matching region wins.
  always_comb begin
    hit_oh   = '0;
    found    = 1'b0;
    off_addr = cpu_addr;
    hit_wait = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!found && region_match(addr_t'(cpu_addr),
                                 addr_t'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                                 addr_t'(REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
        found     = 1'b1;
        hit_oh[i] = 1'b1;
        off_addr  = cpu_addr & ~REGION_MASK[i*ADDR_W +: ADDR_W];
        hit_wait  = REGION_WAIT[i*WS_W +: WS_W];
      end
    end
`ifndef M6809_BUSERR_EN
    if (!found) begin
      hit_oh[NUM_REGIONS-1] = 1'b1;
      off_addr = cpu_addr & ~REGION_MASK[(NUM_REGIONS-1)*ADDR_W +: ADDR_W];
      hit_wait = REGION_WAIT[(NUM_REGIONS-1)*WS_W +: WS_W];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_valid) begin
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          last      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  m6809_wait_counter #(.WS_W(WS_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (hit_wait),
    .dec      (state == ST_ACCESS),
    .zero     (cnt_zero)
  );

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | dev_rdata[i*DATA_W +: DATA_W];
    end
    if (sel_q == '0) rd_mux = UNMAPPED_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      rw_n_q    <= 1'b1;
      dev_addr  <= '0;
      dev_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel_q     <= hit_oh;
        rw_n_q    <= cpu_rw_n;
        dev_addr  <= off_addr;
        dev_wdata <= cpu_wdata;
      end
      if (last && rw_n_q) cpu_rdata <= rd_mux;
    end
  end

  assign dev_sel   = (state == ST_ACCESS) ? sel_q : '0;
  // Gated by reset so an abandoned access never strobes in the reset cycle.
  assign dev_we    = last && !rw_n_q && (sel_q != '0) && !reset;
  assign cpu_ready = (state == ST_RESP);

`ifdef M6809_BUSERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (accept && !found) begin
      fault <= 1'b1;
      if (!fault || fault_clr) fault_addr <= cpu_addr;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault            = 1'b0;
  assign fault_addr       = '0;
`endif

endmodule

// File: tb/tb_m6809_bus_decoder.sv
// Randomized self-checking bench for m6809_bus_decoder against a memory-map reference model.
module tb_m6809_bus_decoder;

`ifdef M6809_BUSERR_EN
  localparam bit BUSERR = 1'b1;
`else
  localparam bit BUSERR = 1'b0;
`endif

  // Region map used by the bench (index 0 first).
  localparam int BASE_A [4] = '{32'h8000, 32'h0000, 32'hC000, 32'h4000};
  localparam int MASK_A [4] = '{32'h8000, 32'hC000, 32'hC000, 32'hF000};
  localparam int WAIT_A [4] = '{0, 3, 1, 15};

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid, cpu_rw_n, fault_clr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, dev_wdata;
  logic        cpu_ready, dev_we, fault;
  logic [3:0]  dev_sel;
  logic [15:0] dev_addr, fault_addr;
  logic [31:0] dev_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_rdata;
  logic        exp_fault;
  logic [15:0] exp_faddr;

  m6809_bus_decoder #(
    .NUM_REGIONS   (4),
    .ADDR_W        (16),
    .DATA_W        (8),
    .WS_W          (4),
    .REGION_BASE   ({16'h4000, 16'hC000, 16'h0000, 16'h8000}),
    .REGION_MASK   ({16'hF000, 16'hC000, 16'hC000, 16'h8000}),
    .REGION_WAIT   ({4'd15, 4'd1, 4'd3, 4'd0}),
    .UNMAPPED_DATA (8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_rw_n   (cpu_rw_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access, checked cycle by cycle against the memory-map rules.
  task automatic do_access(input logic rw_n, input logic [15:0] addr, input logic [7:0] wd, input logic clr);
    int          a, r, w, off, ready_cyc, sel_cnt, we_cnt, we_cyc;
    bit          mapped;
    logic [3:0]  exp_oh, sel_or;
    logic [7:0]  exp_rd, rd_seen, wd_seen;
    logic [15:0] addr_seen;

    a = int'(addr);
    r = -1;
    for (int i = 0; i < 4; i++)
      if (r < 0 && ((a & MASK_A[i]) == (BASE_A[i] & MASK_A[i]))) r = i;
    mapped = (r >= 0);
    if (!mapped && !BUSERR) begin
      r = 3;
      mapped = 1'b1;
    end
    w      = mapped ? WAIT_A[r] : 0;
    off    = mapped ? (a & ~MASK_A[r] & 32'hFFFF) : a;
    exp_oh = mapped ? 4'(1 << r) : 4'b0000;

    dev_rdata = $urandom;
    exp_rd    = mapped ? 8'((dev_rdata >> (8 * r)) & 32'hFF) : 8'hFF;

    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_rw_n  = rw_n;
    cpu_addr  = addr;
    cpu_wdata = wd;
    fault_clr = clr;

    if (BUSERR) begin
      if (!mapped) begin
        if (!exp_fault || clr) exp_faddr = addr;
        exp_fault = 1'b1;
      end else if (clr) begin
        exp_fault = 1'b0;
      end
    end
    if (rw_n) exp_rdata = exp_rd;

    ready_cyc = 0; sel_cnt = 0; we_cnt = 0; we_cyc = 0;
    sel_or = '0; addr_seen = '0; wd_seen = '0; rd_seen = '0;
    for (int k = 1; k <= 40 && ready_cyc == 0; k++) begin
      @(negedge clk);
      fault_clr = 1'b0;
      if (k == 1) begin
        addr_seen = dev_addr;
        wd_seen   = dev_wdata;
      end
      sel_or = sel_or | dev_sel;
      if (dev_sel != 4'b0000) sel_cnt++;
      if (dev_we) begin
        we_cnt++;
        we_cyc = k;
      end
      if (cpu_ready) begin
        ready_cyc = k;
        rd_seen   = cpu_rdata;
        cpu_valid = 1'b0;
      end
    end
    cpu_valid = 1'b0;

    check_eq("ready_latency", ready_cyc, w + 2);
    check_eq("sel_value", sel_or, exp_oh);
    check_eq("sel_cycles", sel_cnt, mapped ? w + 1 : 0);
    check_eq("dev_addr", addr_seen, off);
    check_eq("dev_wdata", wd_seen, wd);
    check_eq("we_count", we_cnt, (!rw_n && mapped) ? 1 : 0);
    if (we_cnt != 0) check_eq("we_cycle", we_cyc, w + 1);
    check_eq("cpu_rdata", rd_seen, exp_rdata);
    check_eq("fault", fault, exp_fault);
    check_eq("fault_addr", fault_addr, exp_faddr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    if (BUSERR) exp_fault = 1'b0;
    check_eq("fault_after_clr", fault, exp_fault);
  endtask

  task automatic reset_mid_access();
    int we_seen;
    we_seen = 0;
    dev_rdata = $urandom;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    @(negedge clk);
    if (dev_we) we_seen++;
    @(negedge clk);
    check_eq("rst_sel_before", dev_sel, 4'b0010);
    reset     = 1'b1;
    cpu_valid = 1'b0;
    #1;
    if (dev_we) we_seen++;
    @(negedge clk);
    check_eq("rst_outputs_zero",
             {cpu_ready, dev_we, dev_sel, dev_addr, dev_wdata, cpu_rdata, fault, fault_addr},
             '0);
    reset = 1'b0;
    exp_rdata = '0; exp_fault = 1'b0; exp_faddr = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dev_we) we_seen++;
    end
    check_eq("rst_no_we", we_seen, 0);
  endtask

  initial begin
    reset = 1'b1; cpu_valid = 1'b0; cpu_rw_n = 1'b1; cpu_addr = '0;
    cpu_wdata = '0; fault_clr = 1'b0; dev_rdata = '0;
    exp_rdata = '0; exp_fault = 1'b0; exp_faddr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_ready", cpu_ready, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_dev_sel", dev_sel, 0);
    check_eq("rst_dev_we", dev_we, 0);
    check_eq("rst_dev_addr", dev_addr, 0);
    check_eq("rst_dev_wdata", dev_wdata, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_fault_addr", fault_addr, 0);
    reset = 1'b0;

    do_access(1'b1, 16'h1234, 8'h00, 1'b0);
    do_access(1'b1, 16'h9000, 8'h00, 1'b0);
    do_access(1'b0, 16'h0010, 8'h5A, 1'b0);
    do_access(1'b1, 16'hC000, 8'h00, 1'b0);
    do_access(1'b1, 16'h4ABC, 8'h00, 1'b0);
    do_access(1'b1, 16'h7F00, 8'h00, 1'b0);
    do_access(1'b1, 16'h7F01, 8'h00, 1'b0);
    pulse_clr();
    do_access(1'b0, 16'h7F02, 8'h33, 1'b0);
    do_access(1'b1, 16'h6000, 8'h00, 1'b1);
    pulse_clr();

    reset_mid_access();
    do_access(1'b1, 16'h9000, 8'h00, 1'b0);

    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      do_access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
